reg_writeback_unit: RTL

- Write-side companion to the 8x8 register file. Collects results from the ALU path and the data-memory load path, queues them, and drives the register file's single write port (write enable, write address, write data).
- Keeps a per-register busy scoreboard so decode can stall on pending writes.
- Sits between execute/data-memory and the register file, closing the register read → execute → write loop.

---
 rtl/reg_writeback_unit_if.sv | 28 ++
 rtl/reg_writeback_unit.sv | 99 +++++++++
 2 files changed

// File: rtl/reg_writeback_unit_if.sv
// Write-back bus bundle: ALU/load result inputs, data-memory read port,
// register-file write port and the busy scoreboard.
interface reg_writeback_unit_if #(parameter int NREG = 8);
  logic            alu_valid;
  logic [2:0]      alu_dest;
  logic [7:0]      alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [2:0]      ld_dest;
  logic [3:0]      ld_addr;
  logic            ld_ready;
  logic            dm_rd_en;
  logic [3:0]      dm_addr;
  logic [7:0]      dm_rdata;
  logic            rf_write;
  logic [2:0]      rf_wr_addr;
  logic [7:0]      rf_wr_data;
  logic [NREG-1:0] busy;

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_addr, dm_rdata,
    output alu_ready, ld_ready, dm_rd_en, dm_addr, rf_write, rf_wr_addr, rf_wr_data, busy
  );
  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_addr, dm_rdata,
    input  alu_ready, ld_ready, dm_rd_en, dm_addr, rf_write, rf_wr_addr, rf_wr_data, busy
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Queues ALU and load results and drains them one per cycle into the
// register-file write port, tracking pending destinations in a busy scoreboard.
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int NREG  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_unit_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]      r_q_dest [DEPTH];
  logic [7:0]      r_q_data [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ld_inflight;
  logic [2:0]      r_ld_dest;
  logic            r_dm_rd_en;
  logic [3:0]      r_dm_addr;
  logic            r_rf_write;
  logic [2:0]      r_rf_wr_addr;
  logic [7:0]      r_rf_wr_data;
  logic [NREG-1:0] r_busy;

  logic [CW-1:0]   w_free;
  logic            w_alu_acc, w_ld_acc, w_push, w_pop;
  logic [2:0]      w_push_dest;
  logic [7:0]      w_push_data;
  logic [NREG-1:0] w_busy_nxt;

  // In-flight load reserves its queue slot so it can always land next cycle
  assign w_free        = CW'(DEPTH) - r_count - CW'(r_ld_inflight);
  assign bus.alu_ready = (w_free != '0) && !r_busy[bus.alu_dest] && !r_ld_inflight;
  assign bus.ld_ready  = (w_free != '0) && !r_busy[bus.ld_dest] && !bus.alu_valid
                         && !r_ld_inflight;
  assign w_alu_acc     = bus.alu_valid && bus.alu_ready;
  assign w_ld_acc      = bus.ld_valid && bus.ld_ready;

  // alu_ready is low while a load is in flight, so the two push sources never collide
  assign w_push      = w_alu_acc || r_ld_inflight;
  assign w_push_dest = r_ld_inflight ? r_ld_dest : bus.alu_dest;
  assign w_push_data = r_ld_inflight ? bus.dm_rdata : bus.alu_data;
  assign w_pop       = (r_count != '0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_write) w_busy_nxt[r_rf_wr_addr] = 1'b0;
    if (w_alu_acc)  w_busy_nxt[bus.alu_dest] = 1'b1;
    if (w_ld_acc)   w_busy_nxt[bus.ld_dest]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_dest[r_wr_ptr] <= w_push_dest;
      r_q_data[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_ld_inflight <= 1'b0;
      r_ld_dest     <= '0;
      r_dm_rd_en    <= 1'b0;
      r_dm_addr     <= '0;
      r_rf_write    <= 1'b0;
      r_rf_wr_addr  <= '0;
      r_rf_wr_data  <= '0;
      r_busy        <= '0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_ld_inflight <= w_ld_acc;
      r_dm_rd_en    <= w_ld_acc;
      if (w_ld_acc) begin
        r_dm_addr <= bus.ld_addr;
        r_ld_dest <= bus.ld_dest;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_rf_write <= w_pop;
      if (w_pop) begin
        r_rf_wr_addr <= r_q_dest[r_rd_ptr];
        r_rf_wr_data <= r_q_data[r_rd_ptr];
      end
    end
  end

  assign bus.dm_rd_en   = r_dm_rd_en;
  assign bus.dm_addr    = r_dm_addr;
  assign bus.rf_write   = r_rf_write;
  assign bus.rf_wr_addr = r_rf_wr_addr;
  assign bus.rf_wr_data = r_rf_wr_data;
  assign bus.busy       = r_busy;
endmodule
